plic_n: RTL and testbench

- Parametrised platform-level interrupt controller. Successor to the fixed two-source PLIC.
- Handles NSRC level-triggered sources with PRIO_W-bit priorities and two targets: context 0 = M-mode, context 1 = S-mode.
- Each context has its own enable set, threshold and claim/complete. Outputs are the registered M and S external-interrupt lines to the core CSR unit.
- Slave on the core AXI4-Lite peripheral bus.

---
 rtl/plic_n.sv | 193 +++++++++++++++++++
 tb/tb_plic_n.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_n.sv
// plic_n: parametrised platform-level interrupt controller with M (ctx 0) and S (ctx 1) targets on AXI4-Lite.
// Optional macro PLIC_EDGE_EN adds the edge_mode register at 0x1080 for per-source edge triggering.
module plic_n #(
    parameter int unsigned NSRC   = 31,
    parameter int unsigned PRIO_W = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NSRC-1:0] irq,
    input  logic [31:0]     axi_araddr,
    input  logic            axi_arvalid,
    output logic            axi_arready,
    input  logic [2:0]      axi_arprot,
    output logic [31:0]     axi_rdata,
    output logic [1:0]      axi_rresp,
    output logic            axi_rvalid,
    input  logic            axi_rready,
    input  logic [31:0]     axi_awaddr,
    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [2:0]      axi_awprot,
    input  logic [31:0]     axi_wdata,
    input  logic [3:0]      axi_wstrb,
    input  logic            axi_wvalid,
    output logic            axi_wready,
    output logic [1:0]      axi_bresp,
    output logic            axi_bvalid,
    input  logic            axi_bready,
    output logic            external_intr_m,
    output logic            external_intr_s
);

    localparam int unsigned IDW = $clog2(NSRC + 1);

    typedef enum logic [2:0] {K_NONE, K_PRIO, K_PEND, K_EDGE, K_EN, K_THR, K_CLAIM} kind_e;

    function automatic kind_e decode(input logic [23:0] off);
        kind_e k;
        k = K_NONE;
        if (off[23:7] == '0 && off[1:0] == 2'b00 && off[6:2] != '0 && 32'(off[6:2]) <= NSRC)
            k = K_PRIO;
        else if (off == 24'h001000) k = K_PEND;
        else if (off == 24'h001080) k = K_EDGE;
        else if (off == 24'h002000 || off == 24'h002080) k = K_EN;
        else if (off == 24'h200000 || off == 24'h201000) k = K_THR;
        else if (off == 24'h200004 || off == 24'h201004) k = K_CLAIM;
        return k;
    endfunction

    logic                up;
    logic [PRIO_W-1:0]   prio [1:NSRC];
    logic [NSRC:0]       pending, in_service, enable [2], edge_mode, edge_set, irq_v;
    logic [PRIO_W-1:0]   thr [2];
    logic [IDW-1:0]      best [2];
    logic [PRIO_W-1:0]   best_p [2];
    logic                unused_ok;

    assign irq_v     = {irq, 1'b0};
    assign unused_ok = ^{axi_arprot, axi_awprot, axi_araddr[31:24], axi_awaddr[31:24]};

    // Highest priority above threshold wins; strict compare keeps the lowest id on ties.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            best[c]   = '0;
            best_p[c] = thr[c];
            for (int i = 1; i <= int'(NSRC); i++) begin
                if (pending[i] && enable[c][i] && prio[i] > best_p[c]) begin
                    best[c]   = IDW'(i);
                    best_p[c] = prio[i];
                end
            end
        end
    end

    assign axi_arready = up & ~axi_rvalid;
    assign axi_awready = up & ~axi_bvalid;
    assign axi_wready  = up & ~axi_bvalid;

    logic           ar_hs, wr_hs, wen, rctx, wctx, claim, cpl;
    kind_e          rkind, wkind;
    logic [IDW-1:0] ridx, widx, claim_id, cpl_id;
    logic [31:0]    rd;
    logic [1:0]     rr;
    logic [NSRC:0]  claim_mask, cpl_mask, pending_n, in_service_n;

    assign ar_hs = axi_arvalid & axi_arready;
    assign wr_hs = axi_awvalid & axi_wvalid & axi_awready;
    assign wen   = wr_hs & (axi_wstrb != 4'b0000);
    assign rkind = decode(axi_araddr[23:0]);
    assign wkind = decode(axi_awaddr[23:0]);
    assign rctx  = (rkind == K_EN) ? axi_araddr[7] : axi_araddr[12];
    assign wctx  = (wkind == K_EN) ? axi_awaddr[7] : axi_awaddr[12];
    assign ridx  = IDW'(axi_araddr[6:2]);
    assign widx  = IDW'(axi_awaddr[6:2]);

    // Read mux; claim returns the combinational best id at the handshake.
    always_comb begin
        rd = '0;
        rr = 2'b00;
        case (rkind)
            K_PRIO:  rd = 32'(prio[ridx]);
            K_PEND:  rd = 32'(pending);
            K_EDGE:  rd = 32'(edge_mode);
            K_EN:    rd = 32'(enable[rctx]);
            K_THR:   rd = 32'(thr[rctx]);
            K_CLAIM: rd = 32'(best[rctx]);
            default: rr = 2'b10;
        endcase
    end

    assign claim_id = best[rctx];
    assign claim    = ar_hs && rkind == K_CLAIM && claim_id != '0;
    assign cpl_id   = IDW'(axi_wdata);
    assign cpl      = wen && wkind == K_CLAIM && axi_wdata != '0 && axi_wdata <= NSRC
                      && in_service[cpl_id] && enable[wctx][cpl_id];

    // Gateway and claim/complete next state, all from pre-edge values.
    always_comb begin
        claim_mask = '0;
        cpl_mask   = '0;
        if (claim) claim_mask[claim_id] = 1'b1;
        if (cpl)   cpl_mask[cpl_id]     = 1'b1;
        pending_n    = (pending | (irq_v & ~pending & ~in_service & ~edge_mode) | edge_set) & ~claim_mask;
        in_service_n = (in_service & ~cpl_mask) | claim_mask;
    end

`ifdef PLIC_EDGE_EN
    logic [NSRC:0] irq_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q     <= '0;
            edge_mode <= '0;
        end else begin
            irq_q <= irq_v;
            if (wen && wkind == K_EDGE) edge_mode <= {axi_wdata[NSRC:1], 1'b0};
        end
    end

    assign edge_set = irq_v & ~irq_q & edge_mode;
`else
    assign edge_mode = '0;
    assign edge_set  = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            up              <= 1'b0;
            axi_rvalid      <= 1'b0;
            axi_rdata       <= '0;
            axi_rresp       <= '0;
            axi_bvalid      <= 1'b0;
            axi_bresp       <= '0;
            pending         <= '0;
            in_service      <= '0;
            external_intr_m <= 1'b0;
            external_intr_s <= 1'b0;
            for (int i = 1; i <= int'(NSRC); i++) prio[i] <= '0;
            for (int c = 0; c < 2; c++) begin
                enable[c] <= '0;
                thr[c]    <= '0;
            end
        end else begin
            up <= 1'b1;
            if (ar_hs) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= rd;
                axi_rresp  <= rr;
            end else if (axi_rready) begin
                axi_rvalid <= 1'b0;
            end
            if (wr_hs) begin
                axi_bvalid <= 1'b1;
                axi_bresp  <= (wkind == K_NONE || wkind == K_PEND) ? 2'b10 : 2'b00;
            end else if (axi_bready) begin
                axi_bvalid <= 1'b0;
            end
            pending    <= pending_n;
            in_service <= in_service_n;
            if (wen) begin
                case (wkind)
                    K_PRIO:  prio[widx]   <= axi_wdata[PRIO_W-1:0];
                    K_EN:    enable[wctx] <= {axi_wdata[NSRC:1], 1'b0};
                    K_THR:   thr[wctx]    <= axi_wdata[PRIO_W-1:0];
                    default: ;
                endcase
            end
            external_intr_m <= (best[0] != '0);
            external_intr_s <= (best[1] != '0);
        end
    end

endmodule

// File: tb/tb_plic_n.sv
// Randomised and directed bench for plic_n against a priority-scan reference model.
module tb_plic_n;
    localparam int NSRC   = 31;
    localparam int PRIO_W = 3;
    localparam int K_NONE = 0, K_PRIO = 1, K_PEND = 2, K_EDGE = 3, K_EN = 4, K_THR = 5, K_CLAIM = 6;

    logic clk, rstn;
    logic [NSRC-1:0] irq;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [2:0] axi_arprot, axi_awprot;
    logic [1:0] axi_rresp, axi_bresp;
    logic [3:0] axi_wstrb;
    logic external_intr_m, external_intr_s;

    plic_n #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .clk(clk), .rstn(rstn), .irq(irq),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .external_intr_m(external_intr_m), .external_intr_s(external_intr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: bit i of each vector is source id i.
    int          m_prio [32];
    int          m_thr [2];
    logic [31:0] m_en [2];
    logic [31:0] m_pend, m_ins, m_edge, m_prev;
    logic [31:0] e_rdata;
    logic [1:0]  e_rresp, e_bresp;

    function automatic void tdec(input logic [31:0] a, output int k, output int idx);
        int off;
        off = int'(a & 32'h00FF_FFFF);
        k = K_NONE;
        idx = 0;
        if (off >= 4 && off <= 4 * NSRC && off % 4 == 0) begin k = K_PRIO; idx = off / 4; end
        else if (off == 'h1000) k = K_PEND;
        else if (off == 'h1080) k = K_EDGE;
        else begin
            for (int c = 0; c < 2; c++) begin
                if (off == 'h2000 + 'h80 * c)     begin k = K_EN;    idx = c; end
                if (off == 'h200000 + 'h1000 * c) begin k = K_THR;   idx = c; end
                if (off == 'h200004 + 'h1000 * c) begin k = K_CLAIM; idx = c; end
            end
        end
    endfunction

    // Scan priority levels top-down; the first enabled pending id at a level is the winner.
    function automatic int m_best(input int c);
        for (int p = (1 << PRIO_W) - 1; p > m_thr[c]; p--)
            for (int i = 1; i <= NSRC; i++)
                if (m_pend[i] && m_en[c][i] && m_prio[i] == p) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_prio[i] = 0;
        m_thr[0] = 0; m_thr[1] = 0; m_en[0] = '0; m_en[1] = '0;
        m_pend = '0; m_ins = '0; m_edge = '0; m_prev = '0;
    endtask

    // One clock: advance the model with the inputs the bench drives, then check the interrupt lines.
    task automatic cycle();
        int b [2];
        int k, idx, id;
        logic [31:0] irqv, set, np, ni;
        @(posedge clk);
        b[0] = m_best(0);
        b[1] = m_best(1);
        irqv = {irq, 1'b0};
        set = '0;
        for (int i = 1; i <= NSRC; i++)
            set[i] = m_edge[i] ? (irqv[i] & ~m_prev[i]) : (irqv[i] & ~m_pend[i] & ~m_ins[i]);
        np = m_pend | set;
        ni = m_ins;
        if (axi_awvalid && axi_wvalid) begin
            tdec(axi_awaddr, k, idx);
            e_bresp = (k == K_NONE || k == K_PEND) ? 2'b10 : 2'b00;
            if (axi_wstrb != 0 && k == K_CLAIM && axi_wdata >= 1 && axi_wdata <= NSRC) begin
                id = int'(axi_wdata);
                if (m_ins[id] && m_en[idx][id]) ni[id] = 1'b0;
            end
        end
        if (axi_arvalid) begin
            tdec(axi_araddr, k, idx);
            e_rresp = (k == K_NONE) ? 2'b10 : 2'b00;
            case (k)
                K_PRIO:  e_rdata = m_prio[idx];
                K_PEND:  e_rdata = m_pend;
                K_EDGE:  e_rdata = m_edge;
                K_EN:    e_rdata = m_en[idx];
                K_THR:   e_rdata = m_thr[idx];
                K_CLAIM: begin
                    id = b[idx];
                    e_rdata = id;
                    if (id != 0) begin np[id] = 1'b0; ni[id] = 1'b1; end
                end
                default: e_rdata = 0;
            endcase
        end
        if (axi_awvalid && axi_wvalid && axi_wstrb != 0) begin
            tdec(axi_awaddr, k, idx);
            case (k)
                K_PRIO: m_prio[idx] = int'(axi_wdata % (1 << PRIO_W));
                K_EN:   m_en[idx] = axi_wdata & 32'hFFFF_FFFE;
                K_THR:  m_thr[idx] = int'(axi_wdata % (1 << PRIO_W));
`ifdef PLIC_EDGE_EN
                K_EDGE: m_edge = axi_wdata & 32'hFFFF_FFFE;
`endif
                default: ;
            endcase
        end
        m_prev = irqv;
        m_pend = np;
        m_ins  = ni;
        #1;
        check("intr_m", 32'(external_intr_m), 32'(b[0] != 0));
        check("intr_s", 32'(external_intr_s), 32'(b[1] != 0));
    endtask

    task automatic do_op(input bit rd, input logic [31:0] ra, input bit wr, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] rdat, output logic [1:0] bres);
        axi_arvalid = rd; axi_araddr = ra;
        axi_awvalid = wr; axi_wvalid = wr; axi_awaddr = wa; axi_wdata = wd; axi_wstrb = ws;
        cycle();
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        rdat = axi_rdata;
        bres = axi_bresp;
        if (rd) begin
            check("rvalid", 32'(axi_rvalid), 1);
            check("rdata", axi_rdata, e_rdata);
            check("rresp", 32'(axi_rresp), 32'(e_rresp));
        end
        if (wr) begin
            check("bvalid", 32'(axi_bvalid), 1);
            check("bresp", 32'(axi_bresp), 32'(e_bresp));
        end
        cycle();
        if (rd) check("rvalid_clr", 32'(axi_rvalid), 0);
        if (wr) check("bvalid_clr", 32'(axi_bvalid), 0);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        logic [1:0] b;
        do_op(1'b1, a, 1'b0, '0, '0, '0, d, b);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic [1:0] b;
        do_op(1'b0, '0, 1'b1, a, d, 4'hF, r, b);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 11))
            0:  a = 4 * $urandom_range(1, NSRC);
            1:  a = 32'h1000;
            2:  a = 32'h1080;
            3:  a = 32'h2000;
            4:  a = 32'h2080;
            5:  a = 32'h200000;
            6:  a = 32'h201000;
            7:  a = 32'h200004;
            8:  a = 32'h201004;
            9:  a = 32'h200004;
            10: a = $urandom & 32'h00FF_FFFF;
            default: a = 4 * $urandom_range(NSRC + 1, 63);
        endcase
        return a | ($urandom & 32'hFF00_0000);
    endfunction

    initial begin
        logic [31:0] d;
        logic [1:0] b;
        rstn = 1'b0; irq = '0; axi_arprot = '0; axi_awprot = '0;
        axi_arvalid = 0; axi_araddr = '0; axi_rready = 1'b1;
        axi_awvalid = 0; axi_wvalid = 0; axi_awaddr = '0; axi_wdata = '0; axi_wstrb = '0; axi_bready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 32'(axi_arready), 0);
        check("rst_awready", 32'(axi_awready), 0);
        check("rst_rvalid", 32'(axi_rvalid), 0);
        check("rst_bvalid", 32'(axi_bvalid), 0);
        check("rst_intr", 32'({external_intr_m, external_intr_s}), 0);
        rstn = 1'b1;
        cycle();
        check("arready_up", 32'(axi_arready), 1);
        check("wready_up", 32'({axi_awready, axi_wready}), 3);

        rd_reg(32'h4, d);      check("prio1_rst", d, 0);
        rd_reg(32'h2000, d);   check("en0_rst", d, 0);
        rd_reg(32'h1000, d);   check("pend_rst", d, 0);
        rd_reg(32'h3000, d);   check("unmapped_data", d, 0);

        // Single source into context 0, claim and complete.
        wr_reg(32'hC, 5); wr_reg(32'h2000, 32'h8); wr_reg(32'h200000, 4);
        irq[2] = 1'b1;
        cycle(); check("intr_m_k1", 32'(external_intr_m), 0);
        cycle(); check("intr_m_k2", 32'(external_intr_m), 1);
        check("intr_s_quiet", 32'(external_intr_s), 0);
        rd_reg(32'h1000, d);   check("pend3", d, 32'h8);
        rd_reg(32'h200004, d); check("claim0", d, 3);
        check("intr_m_drop", 32'(external_intr_m), 0);
        repeat (3) cycle();
        rd_reg(32'h1000, d);   check("no_repend", d, 0);
        wr_reg(32'h200004, 3);
        rd_reg(32'h1000, d);   check("repend", d, 32'h8);
        do_op(1'b0, '0, 1'b1, 32'h200004, 4, 4'hF, d, b); check("cpl_ignored_resp", 32'(b), 0);
        irq[2] = 1'b0;
        rd_reg(32'h200004, d); check("claim0_again", d, 3);
        wr_reg(32'h200004, 3);

        // Tie on priority in context 1.
        wr_reg(32'h8, 6); wr_reg(32'h14, 6); wr_reg(32'h2080, 32'h24); wr_reg(32'h201000, 0);
        irq = NSRC'(32'h12);
        cycle(); irq = '0; cycle(); cycle();
        check("intr_s_on", 32'(external_intr_s), 1);
        rd_reg(32'h201004, d); check("claim1_a", d, 2);
        rd_reg(32'h201004, d); check("claim1_b", d, 5);
        rd_reg(32'h201004, d); check("claim1_none", d, 0);
        wr_reg(32'h201004, 2); wr_reg(32'h201004, 5);
        irq = NSRC'(32'h12);
        cycle(); irq = '0; cycle();
        check("intr_s_again", 32'(external_intr_s), 1);
        wr_reg(32'h201000, 6);
        check("thr_masks_s", 32'(external_intr_s), 0);

        // Truncation, read-only pending, zero strobe, held response.
        wr_reg(32'h200000, 32'hFF);
        rd_reg(32'h200000, d); check("thr_trunc", d, 7);
        do_op(1'b0, '0, 1'b1, 32'h1000, 32'hFFFF, 4'hF, d, b); check("pend_wr_slverr", 32'(b), 2);
        rd_reg(32'h1000, d);   check("pend_ro", d, 32'h24);
        do_op(1'b0, '0, 1'b1, 32'h4, 7, 4'h0, d, b); check("strb0_okay", 32'(b), 0);
        rd_reg(32'h4, d);      check("strb0_noop", d, 0);
        axi_rready = 1'b0; axi_arvalid = 1'b1; axi_araddr = 32'hC;
        cycle(); axi_arvalid = 1'b0;
        repeat (3) cycle();
        check("r_hold_valid", 32'(axi_rvalid), 1);
        check("r_hold_arready", 32'(axi_arready), 0);
        check("r_hold_data", axi_rdata, 5);
        axi_rready = 1'b1;
        cycle(); check("r_hold_release", 32'(axi_rvalid), 0);

`ifdef PLIC_EDGE_EN
        wr_reg(32'h200000, 0); wr_reg(32'h4, 1); wr_reg(32'h2000, 32'h2); wr_reg(32'h1080, 32'h2);
        rd_reg(32'h1080, d);   check("edge_reg", d, 2);
        irq[0] = 1'b1; cycle(); irq[0] = 1'b0; cycle();
        rd_reg(32'h200004, d); check("edge_claim1", d, 1);
        for (int n = 0; n < 2; n++) begin
            irq[0] = 1'b1; cycle(); irq[0] = 1'b0; cycle();
        end
        rd_reg(32'h1000, d);   check("edge_remembered", d & 32'h2, 2);
        wr_reg(32'h200004, 1);
        rd_reg(32'h200004, d); check("edge_claim_once", d, 1);
        rd_reg(32'h200004, d); check("edge_claim_none", d, 0);
        wr_reg(32'h200004, 1);
`else
        rd_reg(32'h1080, d);   check("edge_absent_rd", d, 0);
        do_op(1'b0, '0, 1'b1, 32'h1080, 32'hF, 4'hF, d, b); check("edge_absent_wr", 32'(b), 0);
        rd_reg(32'h1080, d);   check("edge_absent_rd2", d, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] wd;
            logic [3:0] ws;
            irq = irq ^ NSRC'($urandom & $urandom & $urandom);
            op = $urandom_range(0, 3);
            wd = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, NSRC + 2));
            ws = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (op == 0) cycle();
            else do_op(op[0], rand_addr(), op[1], rand_addr(), wd, ws, d, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
